// File: rtl/secure_regfile.sv
// Thread-aware secure register file: per-register owner IDs, privileged thread 0,
// zeroed data on denial and a timed lockout of non-privileged threads after repeated violations.
module secure_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 3,
    parameter int TID_WIDTH      = 4,
    parameter int MAX_VIOL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic                  req_own,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TID_WIDTH-1:0]  req_tid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  lockout,
    output logic [15:0]           viol_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int CNT_W    = $clog2(MAX_VIOL + 1);
    localparam int TMR_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_VIOL);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_OPEN    = 1'b0,
        ST_LOCKOUT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [TMR_W-1:0]      timer_r;
    logic [TMR_W-1:0]      timer_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [DATA_WIDTH-1:0] regs_r  [NUM_REGS];
    logic [TID_WIDTH-1:0]  owner_r [NUM_REGS];
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic [15:0]           viol_count_r;
    logic                  accept_s;
    logic                  tid0_s;
    logic                  own_wr_s;
    logic                  allowed_s;
    logic                  denied_s;

    assign req_ready  = !rsp_valid_r || rsp_ready;
    assign accept_s   = req_valid && req_ready;
    assign tid0_s     = (req_tid == {TID_WIDTH{1'b0}});
    assign own_wr_s   = req_own && req_wr;
    assign denied_s   = accept_s && !allowed_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign lockout    = (state_r == ST_LOCKOUT);
    assign viol_count = viol_count_r;

    // Access permission; thread 0 bypasses ownership and lockout
    always_comb begin
        allowed_s = 1'b0;
        if (tid0_s) begin
            allowed_s = 1'b1;
        end else if (own_wr_s) begin
            allowed_s = 1'b0;
        end else if ((owner_r[req_addr] == req_tid) && (state_r == ST_OPEN)) begin
            allowed_s = 1'b1;
        end else begin
            allowed_s = 1'b0;
        end
    end

    // Lockout FSM next state, timer and consecutive-violation counter
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_OPEN: begin
                if (denied_s) begin
                    if ((cnt_r + CNT_W'(1'b1)) == CNT_MAX) begin
                        state_nxt_s = ST_LOCKOUT;
                        timer_nxt_s = TMR_LOAD;
                    end else begin
                        state_nxt_s = ST_OPEN;
                    end
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                end else if (accept_s && !tid0_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_LOCKOUT: begin
                // Timer runs regardless of traffic; denials here never extend it
                if (timer_r == {TMR_W{1'b0}}) begin
                    state_nxt_s = ST_OPEN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    timer_nxt_s = timer_r - TMR_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_OPEN;
                timer_nxt_s = {TMR_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, lockout timer and consecutive counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_OPEN;
            timer_r <= {TMR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Register and owner storage, written only by allowed accepted writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i]  <= {DATA_WIDTH{1'b0}};
                owner_r[i] <= {TID_WIDTH{1'b0}};
            end
        end else if (accept_s && allowed_s && req_wr) begin
            if (req_own) begin
                owner_r[req_addr] <= req_wdata[TID_WIDTH-1:0];
            end else begin
                regs_r[req_addr] <= req_wdata;
            end
        end
    end

    // One-entry response stage; fields hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= !allowed_s;
            if (allowed_s && !req_wr) begin
                rsp_rdata_r <= regs_r[req_addr];
            end else begin
                rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            end
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Saturating total-violation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_count_r <= 16'h0000;
        end else if (denied_s && (viol_count_r != 16'hFFFF)) begin
            viol_count_r <= viol_count_r + 16'h0001;
        end
    end

endmodule
